// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the configuration-chain loader: register map,
// STATUS bit positions, FSM states and the clock-divider helper.
package fpga_cfg_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LEN    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_FULL     = 2;
    localparam int STAT_EMPTY    = 3;
    localparam int STAT_UNDERRUN = 4;
    localparam int STAT_OVERFLOW = 5;

    localparam logic [7:0] CLKDIV_RST = 8'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_SHIFT,
        S_DONE
    } cfg_state_e;

    // A divider of 0 would give a 2-cycle bit period; it is promoted to 1.
    function automatic logic [7:0] eff_div(input logic [7:0] div);
        return (div == 8'd0) ? 8'd1 : div;
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_fifo.sv
// 32-bit show-ahead word FIFO holding bitstream words until the shifter
// needs them. Flush empties it in one cycle and dominates push/pop.
module cfg_word_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [31:0]              din,
    input  logic                     pop,
    output logic [31:0]              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy update.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Wishbone-slave bitstream loader: buffers words, pulses prog_reset, then
// shifts LEN bits MSB-first into the fabric chain and captures ccff_tail.
//
// state   | meaning
// IDLE    | waiting for START, fabric not isolated
// RST     | prog_reset high for RST_CYCLES cycles, fabric isolated
// SHIFT   | clocking bits out on prog_clk (stalls low on FIFO underrun)
// DONE    | one cycle: set done, pulse cfg_irq, release isolation
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 20,
    parameter int RST_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        ccff_tail,
    output logic        prog_clk,
    output logic        prog_reset,
    output logic        ccff_head,
    output logic        isol_n,
    output logic        cfg_irq
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    cfg_state_e        state_q, state_d;
    logic [15:0]       tmr_q, tmr_d;
    logic [LEN_W-1:0]  bits_q, bits_d, len_q, len_d;
    logic [31:0]       sr_q, sr_d, cap_q, cap_d, dat_q, dat_d;
    logic [5:0]        sr_cnt_q, sr_cnt_d;
    logic [7:0]        clkdiv_q, clkdiv_d, div_e;
    logic              need_q, need_d, pclk_q, pclk_d, head_q, head_d;
    logic              done_q, done_d, unf_q, unf_d, ovf_q, ovf_d, ack_q, ack_d;

    logic              acc, wr, ctrl_wr, len_wr, data_wr, start_req, abort_req;
    logic              fifo_pop, fifo_flush, fifo_full, fifo_empty, want_bit;
    logic [31:0]       fifo_dout, status_w;
    logic [LVL_W-1:0]  fifo_level;
    logic              unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    assign acc       = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr        = acc & wbs_we_i;
    assign ctrl_wr   = wr && (wbs_adr_i[3:2] == REG_CTRL);
    assign len_wr    = wr && (wbs_adr_i[3:2] == REG_LEN);
    assign data_wr   = wr && (wbs_adr_i[3:2] == REG_DATA);
    assign abort_req = ctrl_wr & wbs_dat_i[1];
    assign start_req = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];
    assign div_e     = eff_div(clkdiv_q);

    cfg_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (fifo_flush),
        .push  (data_wr),
        .din   (wbs_dat_i),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Sequencer, shifter and register writes.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        bits_d     = bits_q;
        sr_d       = sr_q;
        sr_cnt_d   = sr_cnt_q;
        need_d     = need_q;
        pclk_d     = pclk_q;
        head_d     = head_q;
        cap_d      = cap_q;
        done_d     = done_q;
        unf_d      = unf_q;
        ovf_d      = ovf_q;
        len_d      = len_q;
        clkdiv_d   = clkdiv_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        want_bit   = 1'b0;

        if (ctrl_wr) clkdiv_d = wbs_dat_i[15:8];
        if (len_wr)  len_d = wbs_dat_i[LEN_W-1:0];
        if (data_wr && fifo_full) ovf_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    done_d   = 1'b0;
                    unf_d    = 1'b0;
                    ovf_d    = 1'b0;
                    sr_cnt_d = '0;
                    bits_d   = len_q;
                    tmr_d    = 16'(RST_CYCLES - 1);
                    state_d  = (len_q == '0) ? S_DONE : S_RST;
                end
            end
            S_RST: begin
                if (tmr_q == '0) begin
                    state_d = S_SHIFT;
                    need_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_SHIFT: begin
                if (need_q) begin
                    want_bit = 1'b1;
                end else if (tmr_q != '0) begin
                    tmr_d = tmr_q - 16'd1;
                end else if (!pclk_q) begin
                    pclk_d = 1'b1;
                    tmr_d  = {8'd0, div_e};
                    cap_d  = {cap_q[30:0], ccff_tail};
                    bits_d = bits_q - LEN_W'(1);
                end else begin
                    pclk_d = 1'b0;
                    if (bits_q == '0) begin
                        state_d = S_DONE;
                        head_d  = 1'b0;
                    end else begin
                        want_bit = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Next bit goes out together with the falling edge of prog_clk.
        if (want_bit) begin
            if (sr_cnt_q != '0) begin
                head_d   = sr_q[31];
                sr_d     = {sr_q[30:0], 1'b0};
                sr_cnt_d = sr_cnt_q - 6'd1;
                need_d   = 1'b0;
                tmr_d    = {8'd0, div_e};
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                head_d   = fifo_dout[31];
                sr_d     = {fifo_dout[30:0], 1'b0};
                sr_cnt_d = 6'd31;
                need_d   = 1'b0;
                tmr_d    = {8'd0, div_e};
            end else begin
                need_d = 1'b1;
                unf_d  = 1'b1;
            end
        end

        if (abort_req && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            pclk_d     = 1'b0;
            head_d     = 1'b0;
            need_d     = 1'b0;
            fifo_pop   = 1'b0;
            fifo_flush = 1'b1;
            done_d     = done_q;
        end
    end

    // Wishbone acknowledge and read-data capture.
    always_comb begin
        status_w                = '0;
        status_w[STAT_BUSY]     = (state_q != S_IDLE);
        status_w[STAT_DONE]     = done_q;
        status_w[STAT_FULL]     = fifo_full;
        status_w[STAT_EMPTY]    = fifo_empty;
        status_w[STAT_UNDERRUN] = unf_q;
        status_w[STAT_OVERFLOW] = ovf_q;
        status_w[15:8]          = 8'(fifo_level);
        ack_d = acc;
        dat_d = dat_q;
        if (acc && !wbs_we_i) begin
            case (wbs_adr_i[3:2])
                REG_CTRL: dat_d = {16'd0, clkdiv_q, 8'd0};
                REG_LEN:  dat_d = 32'(len_q);
                REG_DATA: dat_d = cap_q;
                default:  dat_d = status_w;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            bits_q   <= '0;
            sr_q     <= '0;
            sr_cnt_q <= '0;
            need_q   <= 1'b0;
            pclk_q   <= 1'b0;
            head_q   <= 1'b0;
            cap_q    <= '0;
            done_q   <= 1'b0;
            unf_q    <= 1'b0;
            ovf_q    <= 1'b0;
            len_q    <= '0;
            clkdiv_q <= CLKDIV_RST;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bits_q   <= bits_d;
            sr_q     <= sr_d;
            sr_cnt_q <= sr_cnt_d;
            need_q   <= need_d;
            pclk_q   <= pclk_d;
            head_q   <= head_d;
            cap_q    <= cap_d;
            done_q   <= done_d;
            unf_q    <= unf_d;
            ovf_q    <= ovf_d;
            len_q    <= len_d;
            clkdiv_q <= clkdiv_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign prog_clk   = pclk_q;
    assign ccff_head  = head_q;
    assign prog_reset = (state_q == S_RST);
    assign isol_n     = !(state_q == S_RST || state_q == S_SHIFT);
    assign cfg_irq    = (state_q == S_DONE);

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader: reads and shifted bits push their
// expected values into queues; monitors pop and compare as the DUT presents them.
module tb_fpga_cfg_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel, adr;
    logic [31:0] dat_i, dat_o;
    logic        ack, tail, pclk, preset, head, isol_n, irq;
    logic        loop_en;

    always #5 clk = ~clk;
    assign tail = loop_en ? head : 1'b0;

    fpga_cfg_loader dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .ccff_tail  (tail),
        .prog_clk   (pclk),
        .prog_reset (preset),
        .ccff_head  (head),
        .isol_n     (isol_n),
        .cfg_irq    (irq)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd_exp_q [$];
    string       rd_name_q [$];
    logic        exp_bits [$];

    int   edge_cnt = 0, irq_cnt = 0, rst_hi = 0, isol_bad = 0, per_bad = 0;
    int   cyc_n = 0, last_rise = 0, arm_cyc = 0, exp_period = 0;
    bit   bit_chk_en = 1'b1;
    logic prev_pclk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Register-read scoreboard.
    always @(negedge clk) begin
        if (!rst && ack && !we) begin
            if (rd_exp_q.size() == 0) begin
                chk("unexpected_read_ack", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                string       n;
                e = rd_exp_q.pop_front();
                n = rd_name_q.pop_front();
                chk(n, dat_o, e);
            end
        end
    end

    // Configuration-chain monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_pclk = 1'b0;
        end else begin
            cyc_n++;
            if (irq)    irq_cnt++;
            if (preset) rst_hi++;
            if ((pclk || preset) && isol_n) isol_bad++;
            if (pclk && !prev_pclk) begin
                if (exp_period != 0 && last_rise >= arm_cyc && (cyc_n - last_rise) != exp_period)
                    per_bad++;
                last_rise = cyc_n;
                edge_cnt++;
                if (bit_chk_en) begin
                    if (exp_bits.size() == 0)
                        chk($sformatf("extra_edge%0d", edge_cnt), 32'd1, 32'd0);
                    else
                        chk($sformatf("head_bit_edge%0d", edge_cnt), {31'd0, head}, {31'd0, exp_bits.pop_front()});
                end
            end
            prev_pclk = pclk;
        end
    end

    task automatic wb_access(input logic w, input logic [3:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 10);
        if (!ack) chk("ack_timeout", 32'd0, 32'd1);
        stb = 1'b0; cyc = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        wb_access(1'b1, a, d);
    endtask

    task automatic wb_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        wb_access(1'b0, a, 32'd0);
    endtask

    task automatic push_bits(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) exp_bits.push_back(w[31-i]);
    endtask

    task automatic wait_irq(input int base, input int bound);
        int n;
        n = 0;
        while (irq_cnt == base && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (irq_cnt == base) chk("irq_timeout", 32'd0, 32'd1);
    endtask

    localparam logic [3:0] A_CTRL = 4'h0, A_LEN = 4'h4, A_DATA = 4'h8, A_STAT = 4'hC;

    logic [31:0] words [8] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
                               32'hC3C3C3C3, 32'h3C3C3C3C, 32'h80000001, 32'h7FFFFFFE};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int eb, ib, rb, ob, pb, n;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; adr = 4'h0;
        dat_i = '0; loop_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_isol_n", {31'd0, isol_n}, 32'd1);
        chk("rst_prog_clk", {31'd0, pclk}, 32'd0);
        chk("rst_prog_reset", {31'd0, preset}, 32'd0);
        chk("rst_ccff_head", {31'd0, head}, 32'd0);
        chk("rst_cfg_irq", {31'd0, irq}, 32'd0);
        wb_read(A_CTRL, 32'h0000_0100, "rst_ctrl");
        wb_read(A_LEN,  32'h0, "rst_len");
        wb_read(A_STAT, 32'h0000_0008, "rst_status");
        wb_read(A_DATA, 32'h0, "rst_capture");

        // LEN=40, two words, partial last word
        wb_write(A_LEN, 32'd40);
        wb_write(A_CTRL, 32'h0000_0100);
        wb_write(A_DATA, 32'hA5A5A5A5);
        wb_write(A_DATA, 32'hF0000000);
        push_bits(32'hA5A5A5A5, 32);
        push_bits(32'hF0000000, 8);
        eb = edge_cnt; ib = irq_cnt; rb = rst_hi; ob = isol_bad; pb = per_bad;
        exp_period = 4; arm_cyc = cyc_n;
        wb_write(A_CTRL, 32'h0000_0101);
        wait_irq(ib, 1000);
        repeat (5) @(negedge clk);
        chk("t1_edges", edge_cnt - eb, 40);
        chk("t1_reset_cycles", rst_hi - rb, 16);
        chk("t1_irq_pulses", irq_cnt - ib, 1);
        chk("t1_isol_violations", isol_bad - ob, 0);
        chk("t1_period_errors", per_bad - pb, 0);
        chk("t1_isol_n_after", {31'd0, isol_n}, 32'd1);
        chk("t1_bits_left", exp_bits.size(), 0);
        wb_read(A_STAT, 32'h0000_000A, "t1_status");

        // Loopback capture
        loop_en = 1'b1;
        wb_write(A_LEN, 32'd32);
        wb_write(A_DATA, 32'h12345678);
        push_bits(32'h12345678, 32);
        ib = irq_cnt; arm_cyc = cyc_n;
        wb_write(A_CTRL, 32'h0000_0101);
        wait_irq(ib, 1000);
        repeat (3) @(negedge clk);
        wb_read(A_DATA, 32'h12345678, "t2_capture");
        wb_read(A_STAT, 32'h0000_000A, "t2_status");
        loop_en = 1'b0;

        // Underrun stall and resume
        exp_period = 0;
        wb_write(A_LEN, 32'd64);
        wb_write(A_DATA, 32'hDEADBEEF);
        push_bits(32'hDEADBEEF, 32);
        push_bits(32'h0F0F0F0F, 32);
        eb = edge_cnt; ib = irq_cnt;
        wb_write(A_CTRL, 32'h0000_0101);
        repeat (200) @(negedge clk);
        chk("t3_stall_edges", edge_cnt - eb, 32);
        chk("t3_stall_prog_clk", {31'd0, pclk}, 32'd0);
        wb_read(A_STAT, 32'h0000_0019, "t3_status_stalled");
        wb_write(A_DATA, 32'h0F0F0F0F);
        wait_irq(ib, 1000);
        repeat (3) @(negedge clk);
        chk("t3_edges", edge_cnt - eb, 64);
        wb_read(A_STAT, 32'h0000_001A, "t3_status_done");

        // Overflow then a full 256-bit load
        for (int i = 0; i < 8; i++) wb_write(A_DATA, words[i]);
        wb_write(A_DATA, 32'hBAD0BAD0);
        wb_read(A_STAT, 32'h0000_0836, "t4_status_overflow");
        wb_write(A_LEN, 32'd256);
        for (int i = 0; i < 8; i++) push_bits(words[i], 32);
        eb = edge_cnt; ib = irq_cnt; pb = per_bad;
        exp_period = 4; arm_cyc = cyc_n;
        wb_write(A_CTRL, 32'h0000_0101);
        wait_irq(ib, 3000);
        repeat (3) @(negedge clk);
        chk("t4_edges", edge_cnt - eb, 256);
        chk("t4_period_errors", per_bad - pb, 0);
        chk("t4_bits_left", exp_bits.size(), 0);
        wb_read(A_STAT, 32'h0000_000A, "t4_status");

        // Abort at edge 10
        wb_write(A_LEN, 32'd32);
        wb_write(A_DATA, 32'h55AA55AA);
        wb_write(A_DATA, 32'h11111111);
        push_bits(32'h55AA55AA, 10);
        eb = edge_cnt; ib = irq_cnt; arm_cyc = cyc_n;
        wb_write(A_CTRL, 32'h0000_0101);
        n = 0;
        while ((edge_cnt - eb) < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_edge10", edge_cnt - eb, 10);
        wb_write(A_CTRL, 32'h0000_0102);
        chk("t5_prog_clk", {31'd0, pclk}, 32'd0);
        chk("t5_isol_n", {31'd0, isol_n}, 32'd1);
        chk("t5_prog_reset", {31'd0, preset}, 32'd0);
        repeat (10) @(negedge clk);
        chk("t5_edges", edge_cnt - eb, 10);
        chk("t5_irq_pulses", irq_cnt - ib, 0);
        chk("t5_bits_left", exp_bits.size(), 0);
        wb_read(A_STAT, 32'h0000_0008, "t5_status");

        // Async reset mid-shift
        bit_chk_en = 1'b0; exp_period = 0;
        wb_write(A_CTRL, 32'h0000_0300);
        wb_write(A_LEN, 32'd32);
        wb_write(A_DATA, 32'hCAFEF00D);
        eb = edge_cnt;
        wb_write(A_CTRL, 32'h0000_0301);
        n = 0;
        while ((edge_cnt - eb) < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_edge5", edge_cnt - eb, 5);
        chk("t6_isolated_before_reset", {31'd0, isol_n}, 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t6_isol_n", {31'd0, isol_n}, 32'd1);
        chk("t6_prog_clk", {31'd0, pclk}, 32'd0);
        chk("t6_prog_reset", {31'd0, preset}, 32'd0);
        chk("t6_ccff_head", {31'd0, head}, 32'd0);
        chk("t6_cfg_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_read(A_CTRL, 32'h0000_0100, "t6_ctrl_clkdiv");
        wb_read(A_LEN,  32'h0, "t6_len");
        wb_read(A_STAT, 32'h0000_0008, "t6_status");

        repeat (5) @(negedge clk);
        chk("reads_outstanding", rd_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
Wishbone-slave bitstream loader that drives the fabric configuration chain (prog_clk, prog_reset, ccff_head) from wb_clk_i and captures ccff_tail for readback. Firmware writes a bit count and streams 32-bit words into a small FIFO. The block then sequences prog_reset, shifts the bits MSB-first while holding the fabric isolated, and raises done/irq. It sits in user_project_wrapper between the Wishbone bus and the fabric, replacing GPIO-driven configuration when cfg_sel is set.

Parameters:
FIFO_DEPTH, 8, configuration word FIFO depth in 32-bit words (power of 2, 2..64)
LEN_W, 20, width of the bit-count register
RST_CYCLES, 16, wb_clk_i cycles prog_reset is held high at start

Ports:
wb_clk_i  in  1  single clock; the block generates prog_clk from it
wb_rst_i  in  1  asynchronous, active-high reset
wbs_stb_i  in  1  Wishbone strobe, already decoded for this block
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects; ignored, full-word access only
wbs_adr_i  in  4  address bits [3:2] select the register; [1:0] ignored
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
ccff_tail  in  1  configuration chain tail from the fabric
prog_clk  out  1  configuration clock
prog_reset  out  1  configuration reset, active-high
ccff_head  out  1  configuration chain head
isol_n  out  1  fabric isolation, low while configuring
cfg_irq  out  1  one-cycle pulse when a load completes

Behaviour:
- Reset: all outputs 0 except isol_n=1. FSM=IDLE. FIFO empty. Registers 0. Sticky flags cleared.
- Registers:
  - 0x0 CTRL: bit0 START (write-1, self-clearing). bit1 ABORT (write-1). [15:8] CLKDIV, reset 1.
  - 0x4 LEN: bits to shift, 0..2^LEN_W-1.
  - 0x8 DATA: write pushes a word into the FIFO. Read returns the capture register (last 32 ccff_tail samples; newest sample in bit0).
  - 0xC STATUS, read-only: bit0 busy, bit1 done (sticky), bit2 full, bit3 empty, bit4 underrun (sticky), bit5 overflow (sticky), [15:8] FIFO level.
  - Sticky bits clear on START.
- Wishbone:
  - ack asserts the cycle after stb&cyc and is high for exactly 1 cycle.
  - A new ack is not issued until stb drops or the next access begins. No waitstates beyond this.
  - Write to DATA when full: word dropped, overflow=1.
- FSM states: IDLE, RST, SHIFT, DONE.
  - IDLE: on START with LEN!=0, go to RST: isol_n=0, prog_reset=1 for RST_CYCLES cycles. START with LEN=0 goes directly to DONE.
  - RST -> SHIFT.
  - SHIFT bit period is 2*(CLKDIV+1) cycles.
    - ccff_head updates at the start of the low phase.
    - prog_clk rises after CLKDIV+1 cycles. On the rising edge, ccff_tail is shifted into the capture register.
    - CLKDIV=0 is treated as 1.
  - Words are popped when the previous word is exhausted; bits go out MSB-first. The last word may be partial: only its top LEN mod 32 bits are used.
  - If the FIFO is empty when a word is needed: prog_clk is held low, underrun=1 (sticky), and shifting resumes the cycle after the FIFO becomes non-empty.
  - After LEN rising edges, prog_clk returns low -> DONE.
  - DONE: lasts 1 cycle. isol_n=1, done=1, cfg_irq=1 pulse -> IDLE. Leftover FIFO words remain.
- ABORT in any non-IDLE state:
  - Next cycle: prog_clk=0, prog_reset=0, isol_n=1, FIFO flushed, -> IDLE.
  - done is not set and there is no irq.
- START while busy is ignored. A CTRL write with START and ABORT together is treated as ABORT.
- An async reset mid-shift returns all outputs to reset values immediately; there is no glitch requirement on prog_clk beyond this.

Decomposition:
- Package fpga_cfg_pkg holds:
  - register offsets (CTRL/LEN/DATA/STATUS)
  - STATUS bit indices
  - FSM state enum
  - CLKDIV reset value
- Sub-module cfg_word_fifo: synchronous FIFO, 32-bit, FIFO_DEPTH entries, push/pop/full/empty/level, async active-high reset, flush input.

Test Plan:
- LEN=40, CLKDIV=1, push 0xA5A5A5A5 and 0xF0000000, START -> prog_reset high 16 cycles, then 40 prog_clk pulses of 4-cycle period; ccff_head sequence 1010... then 11110000; done=1, cfg_irq one pulse, isol_n low throughout and 1 after.
- Loopback ccff_tail=ccff_head, LEN=32, push 0x12345678 -> DATA read returns 0x12345678, STATUS=0x0002 plus empty bit.
- LEN=64 with one word pushed, START, wait 200 cycles -> prog_clk stalled low after 32 edges, underrun=1; push second word -> remaining 32 edges, done=1.
- Push 9 words with FIFO_DEPTH=8 -> overflow=1, level=8; START with LEN=256 completes with exactly 256 edges.
- ABORT at edge 10 of LEN=32 -> next cycle prog_clk=0, isol_n=1, FIFO empty, busy=0, done=0, no irq.
- Assert wb_rst_i mid-SHIFT -> outputs reset immediately (isol_n=1, others 0); CLKDIV reads back 1.
